pli_assert_monitor: RTL and testbench
=====================================

Name: pli_assert_monitor

Overview:
- Synthesizable assertion and message monitor that replaces the simulator-side checking tasks with hardware checks.
- Instantiated once at the top level of a design.
- Counts info, warning and error events.
- Checks generic assertions, at-most-one-hot vectors, exactly-one-hot vectors, and a request/acknowledge handshake.
- Raises sticky fail and stop flags that the environment uses to end a run.

Parameters:
WIDTH, 3, width of the vectors checked for at-most-one-hot and one-hot.
DATA_W, 32, width of the request payload.
TIMEOUT, 4, maximum cycles from req to ack (valid range 1..255).
ERR_LIMIT, 1, error_count value at which stop asserts (must be 1 or more).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
info_valid  in  1  info message event
warn_valid  in  1  warning message event
error_valid  in  1  explicit error event
assert_valid  in  1  generic assertion is evaluated this cycle
assert_cond  in  1  assertion condition; 0 means failure
amone_valid  in  1  at-most-one-hot check is evaluated this cycle
amone_vec  in  WIDTH  vector for the at-most-one-hot check
onehot_valid  in  1  one-hot check is evaluated this cycle
onehot_vec  in  WIDTH  vector for the one-hot check
req  in  1  request, single-cycle pulse
ack  in  1  acknowledge, single-cycle pulse
req_data  in  DATA_W  payload, sampled when req=1
info_count  out  16  info events seen
warn_count  out  16  warning events seen
error_count  out  16  failures seen
fail  out  1  sticky: at least one failure has occurred
fail_code  out  3  cause of the first failure
stop  out  1  sticky: error_count has reached ERR_LIMIT
req_pending  out  1  a request is outstanding
req_data_q  out  DATA_W  payload captured at the last accepted req

Behaviour:
- Reset: all outputs are 0 and the handshake timer is 0. All state is registered; outputs update on the clk edge after the event.
- Failure sources, each counted once per cycle when true:
  - code 1: assert_valid & !assert_cond
  - code 2: amone_valid & popcount(amone_vec) > 1
  - code 3: onehot_valid & popcount(onehot_vec) != 1
  - code 4: req while req_pending=1
  - code 5: ack while req_pending=0
  - code 6: handshake timeout
  - code 7: error_valid
- Vectors 000, 001, 010, 100 pass the at-most-one-hot check. 011 and 110 fail it.
- Vectors 01 and 10 pass the one-hot check. 00 and 11 fail it.
- Counters:
  - info_count increments by 1 per cycle with info_valid=1.
  - warn_count increments by 1 per cycle with warn_valid=1.
  - error_count increments by the number of failure sources active that cycle (0..7).
  - All counters saturate at 16'hFFFF.
- fail sets on the first failure and stays set until reset.
- fail_code latches on the first failure only. If several sources fire in that same cycle, the lowest code wins.
- stop sets on the edge where the updated error_count >= ERR_LIMIT and stays set until reset.
  - Warnings and info events never set fail or stop.
  - While stop=1, all counting and checking continues.
- Handshake:
  - An accepted req (req=1 and req_pending=0) sets req_pending, loads req_data_q and clears the timer.
  - While pending, the timer increments each cycle.
  - ack in a cycle after the req cycle with timer < TIMEOUT clears req_pending: pass.
  - If the timer reaches TIMEOUT with no ack, raise code 6 once and clear req_pending.
  - req and ack in the same cycle while pending: the ack completes the old request and the new req is accepted (no failure). The same combination while not pending is code 5 plus an accepted req.
  - A req while pending (without ack) is code 4 and is not accepted; req_data_q is kept.
- Reset in the middle of a handshake drops the pending state with no failure.

Test Plan:
- Reset, then one cycle of info_valid=1 -> info_count=1, error_count=0, fail=0, stop=0.
- amone_vec=100, 010, 001, 000 on consecutive cycles; onehot_vec=10, then 01 -> no failure. Then amone_vec=011 -> fail=1, fail_code=2, error_count=1, stop=1 (ERR_LIMIT=1).
- req with req_data=32'hFEED, ack two cycles later -> req_pending is 1 for 2 cycles, req_data_q=32'hFEED, no failure.
- req, then no ack for TIMEOUT=4 cycles -> fail_code=6, req_pending=0, error_count=1.
- ack with no outstanding req -> fail_code=5. A second req while pending -> code 4, error_count increments, req_data_q unchanged.
- Same cycle: assert_cond=0 and error_valid=1 -> error_count=2, fail_code=1. warn_valid for 20 cycles -> warn_count=20 and stop is not set by warnings. Reset -> all outputs 0.

Source files
------------

// File: rtl/pli_assert_monitor.sv
`default_nettype none
// ============================================================================
// Module   : pli_assert_monitor
// Purpose  : Hardware assertion/message monitor. Counts info, warning and
//            error events, evaluates generic assertions, at-most-one-hot and
//            exactly-one-hot vector checks and a req/ack handshake with a
//            timeout. Raises sticky fail/stop flags to end a run.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            info/warn/error_valid - message events
//            assert_valid/cond   - generic assertion (cond=0 is a failure)
//            amone_valid/vec     - at-most-one-hot check
//            onehot_valid/vec    - exactly-one-hot check
//            req, ack, req_data  - handshake being monitored
//            info/warn/error_count - saturating 16-bit event counters
//            fail, fail_code     - sticky failure flag and first cause
//            stop                - sticky, error_count reached ERR_LIMIT
//            req_pending, req_data_q - handshake state and captured payload
// Revision : 1.0 - initial release
// ============================================================================
module pli_assert_monitor #(
    parameter int WIDTH     = 3,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 4,
    parameter int ERR_LIMIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              info_valid,
    input  logic              warn_valid,
    input  logic              error_valid,
    input  logic              assert_valid,
    input  logic              assert_cond,
    input  logic              amone_valid,
    input  logic [WIDTH-1:0]  amone_vec,
    input  logic              onehot_valid,
    input  logic [WIDTH-1:0]  onehot_vec,
    input  logic              req,
    input  logic              ack,
    input  logic [DATA_W-1:0] req_data,
    output logic [15:0]       info_count,
    output logic [15:0]       warn_count,
    output logic [15:0]       error_count,
    output logic              fail,
    output logic [2:0]        fail_code,
    output logic              stop,
    output logic              req_pending,
    output logic [DATA_W-1:0] req_data_q
);

    localparam logic [7:0]  c_timeout   = 8'(TIMEOUT);
    localparam logic [31:0] c_err_limit = ERR_LIMIT;

    logic [7:0]  r_timer;
    logic [7:0]  w_timer_inc;
    logic        w_accept;
    logic        w_timeout;
    logic [7:1]  w_src;
    logic [2:0]  w_num_src;
    logic [2:0]  w_first_code;
    logic [16:0] w_err_sum;
    logic [15:0] w_err_next;

    assign w_timer_inc = r_timer + 8'd1;

    // A req is accepted when idle, or when the same-cycle ack retires the
    // outstanding request.
    assign w_accept  = req & (~req_pending | ack);

    // The timer counts completed pending cycles; the cycle that would bring
    // it to TIMEOUT without an ack is the timeout.
    assign w_timeout = req_pending & ~ack & (w_timer_inc == c_timeout);

    assign w_src[1] = assert_valid & ~assert_cond;
    assign w_src[2] = amone_valid & ($countones(amone_vec) > 1);
    assign w_src[3] = onehot_valid & ($countones(onehot_vec) != 1);
    assign w_src[4] = req & req_pending & ~ack;
    assign w_src[5] = ack & ~req_pending;
    assign w_src[6] = w_timeout;
    assign w_src[7] = error_valid;

    assign w_num_src = 3'($countones(w_src));

    // Lowest active code wins when several sources fire together.
    always_comb begin
        w_first_code = 3'd0;
        for (int i = 7; i >= 1; i--) begin
            if (w_src[i]) begin
                w_first_code = 3'(i);
            end
        end
    end

    assign w_err_sum  = {1'b0, error_count} + {14'd0, w_num_src};
    assign w_err_next = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            info_count  <= 16'd0;
            warn_count  <= 16'd0;
            error_count <= 16'd0;
            fail        <= 1'b0;
            fail_code   <= 3'd0;
            stop        <= 1'b0;
            req_pending <= 1'b0;
            req_data_q  <= '0;
            r_timer     <= 8'd0;
        end else begin
            if (info_valid && (info_count != 16'hFFFF)) begin
                info_count <= info_count + 16'd1;
            end
            if (warn_valid && (warn_count != 16'hFFFF)) begin
                warn_count <= warn_count + 16'd1;
            end

            error_count <= w_err_next;

            if (!fail && (w_src != 7'd0)) begin
                fail      <= 1'b1;
                fail_code <= w_first_code;
            end

            if ({16'd0, w_err_next} >= c_err_limit) begin
                stop <= 1'b1;
            end

            if (w_accept) begin
                req_pending <= 1'b1;
                req_data_q  <= req_data;
                r_timer     <= 8'd0;
            end else if (req_pending) begin
                if (ack || w_timeout) begin
                    req_pending <= 1'b0;
                end
                r_timer <= w_timer_inc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pli_assert_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pli_assert_monitor
// Purpose  : Self-checking bench for pli_assert_monitor. Single-cycle table
//            vectors from reset plus multi-cycle handshake/message sequences;
//            expected records go through a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pli_assert_monitor;

    typedef struct packed {
        logic        info;
        logic        warn;
        logic        err;
        logic        av;
        logic        ac;
        logic        amv;
        logic [2:0]  amvec;
        logic        ohv;
        logic [2:0]  ohvec;
        logic        rq;
        logic        ak;
        logic [31:0] data;
    } stim_t;

    typedef struct packed {
        logic [15:0] ic;
        logic [15:0] wc;
        logic [15:0] ec;
        logic        fail;
        logic [2:0]  code;
        logic        stop;
        logic        pend;
        logic [31:0] dq;
    } exp_t;

    typedef struct {
        string name;
        stim_t s;
        exp_t  e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        info_valid, warn_valid, error_valid;
    logic        assert_valid, assert_cond;
    logic        amone_valid, onehot_valid;
    logic [2:0]  amone_vec, onehot_vec;
    logic        req, ack;
    logic [31:0] req_data;
    logic [15:0] info_count, warn_count, error_count;
    logic        fail, stop, req_pending;
    logic [2:0]  fail_code;
    logic [31:0] req_data_q;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    localparam stim_t IDLE = '0;

    pli_assert_monitor #(
        .WIDTH(3), .DATA_W(32), .TIMEOUT(4), .ERR_LIMIT(1)
    ) dut (
        .clk(clk), .reset(reset),
        .info_valid(info_valid), .warn_valid(warn_valid), .error_valid(error_valid),
        .assert_valid(assert_valid), .assert_cond(assert_cond),
        .amone_valid(amone_valid), .amone_vec(amone_vec),
        .onehot_valid(onehot_valid), .onehot_vec(onehot_vec),
        .req(req), .ack(ack), .req_data(req_data),
        .info_count(info_count), .warn_count(warn_count), .error_count(error_count),
        .fail(fail), .fail_code(fail_code), .stop(stop),
        .req_pending(req_pending), .req_data_q(req_data_q)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic exp_t ex(int ic, int wc, int ec, int code, bit stp,
                                bit pend, logic [31:0] dq);
        exp_t e;
        e.ic   = 16'(ic);
        e.wc   = 16'(wc);
        e.ec   = 16'(ec);
        e.fail = (code != 0);
        e.code = 3'(code);
        e.stop = stp;
        e.pend = pend;
        e.dq   = dq;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        info_valid   = s.info;
        warn_valid   = s.warn;
        error_valid  = s.err;
        assert_valid = s.av;
        assert_cond  = s.ac;
        amone_valid  = s.amv;
        amone_vec    = s.amvec;
        onehot_valid = s.ohv;
        onehot_vec   = s.ohvec;
        req          = s.rq;
        ack          = s.ak;
        req_data     = s.data;
    endtask

    task automatic check(input string name);
        exp_t got, e;
        got.ic = info_count;   got.wc = warn_count; got.ec = error_count;
        got.fail = fail;       got.code = fail_code; got.stop = stop;
        got.pend = req_pending; got.dq = req_data_q;
        e = sb_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s: got ic=%0d wc=%0d ec=%0d fail=%0b code=%0d stop=%0b pend=%0b dq=%h, expected ic=%0d wc=%0d ec=%0d fail=%0b code=%0d stop=%0b pend=%0b dq=%h",
                     name, got.ic, got.wc, got.ec, got.fail, got.code, got.stop, got.pend, got.dq,
                     e.ic, e.wc, e.ec, e.fail, e.code, e.stop, e.pend, e.dq);
        end
    endtask

    // Drive one cycle of stimulus, then compare after the edge.
    task automatic step(input string name, input stim_t s, input exp_t e);
        apply(s);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check(name);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply(IDLE);
        sb_q.push_back(ex(0, 0, 0, 0, 0, 0, 32'h0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_state");
    endtask

    task automatic add(input string n, input stim_t s, input exp_t e);
        vec_t v;
        v.name = n; v.s = s; v.e = e;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        apply(IDLE);

        add("info",          '{default:'0, info:1'b1},                      ex(1,0,0,0,0,0,0));
        add("warn",          '{default:'0, warn:1'b1},                      ex(0,1,0,0,0,0,0));
        add("assert_pass",   '{default:'0, av:1'b1, ac:1'b1},               ex(0,0,0,0,0,0,0));
        add("assert_fail",   '{default:'0, av:1'b1},                        ex(0,0,1,1,1,0,0));
        add("amone_100",     '{default:'0, amv:1'b1, amvec:3'b100},         ex(0,0,0,0,0,0,0));
        add("amone_000",     '{default:'0, amv:1'b1, amvec:3'b000},         ex(0,0,0,0,0,0,0));
        add("amone_011",     '{default:'0, amv:1'b1, amvec:3'b011},         ex(0,0,1,2,1,0,0));
        add("amone_110",     '{default:'0, amv:1'b1, amvec:3'b110},         ex(0,0,1,2,1,0,0));
        add("amone_111",     '{default:'0, amv:1'b1, amvec:3'b111},         ex(0,0,1,2,1,0,0));
        add("onehot_010",    '{default:'0, ohv:1'b1, ohvec:3'b010},         ex(0,0,0,0,0,0,0));
        add("onehot_000",    '{default:'0, ohv:1'b1, ohvec:3'b000},         ex(0,0,1,3,1,0,0));
        add("onehot_011",    '{default:'0, ohv:1'b1, ohvec:3'b011},         ex(0,0,1,3,1,0,0));
        add("error_valid",   '{default:'0, err:1'b1},                       ex(0,0,1,7,1,0,0));
        add("ack_alone",     '{default:'0, ak:1'b1},                        ex(0,0,1,5,1,0,0));
        add("req_accept",    '{default:'0, rq:1'b1, data:32'hFEED},         ex(0,0,0,0,0,1,32'hFEED));
        add("req_ack_idle",  '{default:'0, rq:1'b1, ak:1'b1, data:32'h77},  ex(0,0,1,5,1,1,32'h77));
        add("assert_and_err",'{default:'0, av:1'b1, err:1'b1},              ex(0,0,2,1,1,0,0));
        add("many_sources",  '{default:'0, av:1'b1, amv:1'b1, amvec:3'b011, ohv:1'b1,
                               ohvec:3'b000, ak:1'b1, rq:1'b1, err:1'b1, data:32'hAB},
                                                                            ex(0,0,5,1,1,1,32'hAB));
        add("checks_invalid",'{default:'0, amvec:3'b111, ohvec:3'b000},     ex(0,0,0,0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            do_reset();
            step(vecs[i].name, vecs[i].s, vecs[i].e);
        end

        // Vector checks across consecutive cycles, then a first failure.
        do_reset();
        step("seqA_info", '{default:'0, info:1'b1}, ex(1,0,0,0,0,0,0));
        step("seqA_am100", '{default:'0, amv:1'b1, amvec:3'b100, ohv:1'b1, ohvec:3'b010}, ex(1,0,0,0,0,0,0));
        step("seqA_am010", '{default:'0, amv:1'b1, amvec:3'b010, ohv:1'b1, ohvec:3'b001}, ex(1,0,0,0,0,0,0));
        step("seqA_am001", '{default:'0, amv:1'b1, amvec:3'b001}, ex(1,0,0,0,0,0,0));
        step("seqA_am000", '{default:'0, amv:1'b1, amvec:3'b000}, ex(1,0,0,0,0,0,0));
        step("seqA_am011", '{default:'0, amv:1'b1, amvec:3'b011}, ex(1,0,1,2,1,0,0));

        // Handshake completed two cycles after req.
        do_reset();
        step("seqB_req",  '{default:'0, rq:1'b1, data:32'hFEED}, ex(0,0,0,0,0,1,32'hFEED));
        step("seqB_wait", IDLE,                                  ex(0,0,0,0,0,1,32'hFEED));
        step("seqB_ack",  '{default:'0, ak:1'b1},                ex(0,0,0,0,0,0,32'hFEED));

        // Ack in the last legal cycle (timer = TIMEOUT-1).
        do_reset();
        step("seqB2_req", '{default:'0, rq:1'b1, data:32'h5}, ex(0,0,0,0,0,1,32'h5));
        for (int i = 0; i < 3; i++) step("seqB2_wait", IDLE,  ex(0,0,0,0,0,1,32'h5));
        step("seqB2_ack", '{default:'0, ak:1'b1},             ex(0,0,0,0,0,0,32'h5));

        // Timeout: no ack for TIMEOUT cycles, reported once.
        do_reset();
        step("seqC_req", '{default:'0, rq:1'b1, data:32'h1234}, ex(0,0,0,0,0,1,32'h1234));
        for (int i = 0; i < 3; i++) step("seqC_wait", IDLE,     ex(0,0,0,0,0,1,32'h1234));
        step("seqC_timeout", IDLE,                              ex(0,0,1,6,1,0,32'h1234));
        step("seqC_after",   IDLE,                              ex(0,0,1,6,1,0,32'h1234));

        // Protocol errors: stray ack, req while pending, req+ack while pending.
        do_reset();
        step("seqD_ack",      '{default:'0, ak:1'b1},               ex(0,0,1,5,1,0,32'h0));
        step("seqD_reqA",     '{default:'0, rq:1'b1, data:32'hA},   ex(0,0,1,5,1,1,32'hA));
        step("seqD_reqB",     '{default:'0, rq:1'b1, data:32'hB},   ex(0,0,2,5,1,1,32'hA));
        step("seqD_reqC_ack", '{default:'0, rq:1'b1, ak:1'b1, data:32'hC}, ex(0,0,2,5,1,1,32'hC));
        step("seqD_ack_end",  '{default:'0, ak:1'b1},               ex(0,0,2,5,1,0,32'hC));

        // Two sources in one cycle; then warnings alone never stop the run.
        do_reset();
        step("seqE_two_src", '{default:'0, av:1'b1, err:1'b1}, ex(0,0,2,1,1,0,0));
        do_reset();
        for (int i = 0; i < 20; i++) step("seqE_warn", '{default:'0, warn:1'b1}, ex(0,i+1,0,0,0,0,0));

        // Reset in the middle of a handshake drops it silently.
        step("seqF_req", '{default:'0, rq:1'b1, data:32'h99}, ex(0,20,0,0,0,1,32'h99));
        do_reset();
        for (int i = 0; i < 6; i++) step("seqF_idle", IDLE, ex(0,0,0,0,0,0,0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
